// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: two read ports sharing one cache controller.
// Round-robin on contention, per-transaction wait timeout, registered data.
module cache_port_arbiter #(
    parameter logic [15:0] WAIT_LIMIT = 16'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p0_addr,
    input  logic        p0_re,
    output logic [31:0] p0_data,
    output logic        p0_end,
    output logic        p0_err,
    input  logic [31:0] p1_addr,
    input  logic        p1_re,
    output logic [31:0] p1_data,
    output logic        p1_end,
    output logic        p1_err,
    output logic [31:0] ctrl_addr,
    output logic        ctrl_re,
    input  logic [31:0] ctrl_data_read,
    input  logic        ctrl_read_end,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        owner_nxt;
    logic        last_served;
    logic [31:0] addr_q;
    logic [15:0] wait_cnt;
    logic [16:0] wait_inc;
    logic        err_q;
    logic        timeout;
    logic        resp;

    assign wait_inc = {1'b0, wait_cnt} + 17'd1;
    assign timeout  = wait_inc >= {1'b0, WAIT_LIMIT};

    // State and owner registers; reset aborts any transaction at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next state and owner selection (round-robin against last_served)
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            IDLE: begin
                if (p0_re || p1_re) begin
                    state_nxt = ISSUE;
                    if (p0_re && p1_re) owner_nxt = ~last_served;
                    else                owner_nxt = p1_re;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (ctrl_read_end || timeout) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address latch, wait counter, error flag, fairness pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= 32'd0;
            wait_cnt    <= 16'd0;
            err_q       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            if (state == IDLE && state_nxt == ISSUE)
                addr_q <= owner_nxt ? p1_addr : p0_addr;
            if (state == ISSUE) begin
                wait_cnt <= 16'd0;
                err_q    <= 1'b0;
            end
            if (state == WAIT && !ctrl_read_end) begin
                if (wait_cnt != 16'hFFFF) wait_cnt <= wait_inc[15:0];
                if (timeout)              err_q    <= 1'b1;
            end
            if (state == RESP) last_served <= owner;
        end
    end

    // Per-port data registers; only a real completion updates the owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_data <= 32'd0;
            p1_data <= 32'd0;
        end else if (state == WAIT && ctrl_read_end) begin
            if (owner) p1_data <= ctrl_data_read;
            else       p0_data <= ctrl_data_read;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy      = state != IDLE;
        ctrl_re   = (state == ISSUE) || (state == WAIT);
        ctrl_addr = busy ? addr_q : 32'd0;
        grant     = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
        resp      = state == RESP;
        p0_end    = resp && !owner;
        p1_end    = resp && owner;
        p0_err    = p0_end && err_q;
        p1_err    = p1_end && err_q;
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed + random checks of cache_port_arbiter
// against a transaction-level reference model.
module tb_cache_port_arbiter;

    localparam logic [15:0] LIM = 16'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] p0_addr = 32'd0;
    logic        p0_re = 1'b0;
    logic [31:0] p0_data;
    logic        p0_end;
    logic        p0_err;
    logic [31:0] p1_addr = 32'd0;
    logic        p1_re = 1'b0;
    logic [31:0] p1_data;
    logic        p1_end;
    logic        p1_err;
    logic [31:0] ctrl_addr;
    logic        ctrl_re;
    logic [31:0] ctrl_data_read = 32'd0;
    logic        ctrl_read_end = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    cache_port_arbiter #(.WAIT_LIMIT(LIM)) dut (
        .clk            (clk),
        .reset          (reset),
        .p0_addr        (p0_addr),
        .p0_re          (p0_re),
        .p0_data        (p0_data),
        .p0_end         (p0_end),
        .p0_err         (p0_err),
        .p1_addr        (p1_addr),
        .p1_re          (p1_re),
        .p1_data        (p1_data),
        .p1_end         (p1_end),
        .p1_err         (p1_err),
        .ctrl_addr      (ctrl_addr),
        .ctrl_re        (ctrl_re),
        .ctrl_data_read (ctrl_data_read),
        .ctrl_read_end  (ctrl_read_end),
        .grant          (grant),
        .busy           (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, counted in cycles since grant
    bit          m_act = 1'b0;
    bit          m_own = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    bit          m_last = 1'b1;
    int          m_t = 0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_data [2] = '{32'd0, 32'd0};

    function automatic bit pick(bit r0, bit r1, bit last);
        return (r0 && r1) ? !last : r1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act     <= 1'b0;
            m_done    <= 1'b0;
            m_err     <= 1'b0;
            m_last    <= 1'b1;
            m_t       <= 0;
            m_addr    <= 32'd0;
            m_data[0] <= 32'd0;
            m_data[1] <= 32'd0;
        end else if (!m_act) begin
            if (p0_re || p1_re) begin
                m_own  <= pick(p0_re, p1_re, m_last);
                m_addr <= pick(p0_re, p1_re, m_last) ? p1_addr : p0_addr;
                m_act  <= 1'b1;
                m_t    <= 0;
                m_done <= 1'b0;
                m_err  <= 1'b0;
            end
        end else if (m_done) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_last <= m_own;
        end else if (m_t == 0) begin
            m_t <= 1;
        end else if (ctrl_read_end) begin
            m_data[m_own] <= ctrl_data_read;
            m_done        <= 1'b1;
        end else if (m_t >= int'(LIM)) begin
            m_done <= 1'b1;
            m_err  <= 1'b1;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic [1:0]  e_grant;
    logic        e_re;
    logic [31:0] e_addr;
    logic        e_end0;
    logic        e_end1;
    assign e_grant = m_act ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    assign e_re    = m_act && !m_done;
    assign e_addr  = m_act ? m_addr : 32'd0;
    assign e_end0  = m_act && m_done && !m_own;
    assign e_end1  = m_act && m_done && m_own;

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_act));
        chk("grant", 32'(grant), 32'(e_grant));
        chk("ctrl_re", 32'(ctrl_re), 32'(e_re));
        chk("ctrl_addr", ctrl_addr, e_addr);
        chk("p0_end", 32'(p0_end), 32'(e_end0));
        chk("p1_end", 32'(p1_end), 32'(e_end1));
        chk("p0_err", 32'(p0_err), 32'(e_end0 && m_err));
        chk("p1_err", 32'(p1_err), 32'(e_end1 && m_err));
        chk("p0_data", p0_data, m_data[0]);
        chk("p1_data", p1_data, m_data[1]);
    end

    bit auto_resp = 1'b0;

    task automatic cyc();
        @(negedge clk);
        if (auto_resp) begin
            ctrl_read_end  = ($urandom_range(0, 3) == 0);
            ctrl_data_read = $urandom;
        end
    endtask

    task automatic wait_busy(input logic v, input string nm);
        int n = 0;
        while (busy !== v && n < 200) begin
            cyc();
            n++;
        end
        chk(nm, 32'(busy), 32'(v));
    endtask

    logic [1:0]  gseq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] keep1;
    int          n;

    initial begin
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ctrl_re", 32'(ctrl_re), 32'd0);
        chk("rst_ctrl_addr", ctrl_addr, 32'd0);
        chk("rst_p0_data", p0_data, 32'd0);
        chk("rst_p1_data", p1_data, 32'd0);
        chk("rst_ends", 32'({p1_end, p0_end, p1_err, p0_err}), 32'd0);

        // Single p0 read completing after three wait cycles
        reset   = 1'b1;
        p0_re   = 1'b1;
        p0_addr = 32'h0000_0200;
        cyc();
        chk("t1_ctrl_re", 32'(ctrl_re), 32'd1);
        chk("t1_ctrl_addr", ctrl_addr, 32'h0000_0200);
        chk("t1_grant", 32'(grant), 32'd1);
        p0_re = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t1_wait_re", 32'(ctrl_re), 32'd1);
        ctrl_read_end  = 1'b1;
        ctrl_data_read = 32'h1234_5678;
        cyc();
        ctrl_read_end = 1'b0;
        chk("t1_p0_end", 32'(p0_end), 32'd1);
        chk("t1_p0_err", 32'(p0_err), 32'd0);
        chk("t1_p0_data", p0_data, 32'h1234_5678);
        chk("t1_resp_re", 32'(ctrl_re), 32'd0);
        chk("t1_p1_untouched", p1_data, 32'd0);
        chk("t1_p1_end", 32'(p1_end), 32'd0);
        cyc();
        chk("t1_end_pulse", 32'(p0_end), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Stray completions in IDLE and ISSUE
        ctrl_read_end  = 1'b1;
        ctrl_data_read = 32'hDEAD_BEEF;
        cyc();
        chk("t2_idle_end", 32'(p0_end), 32'd0);
        chk("t2_idle_data", p0_data, 32'h1234_5678);
        ctrl_read_end = 1'b0;
        p0_re   = 1'b1;
        p0_addr = 32'h0000_0300;
        cyc();
        ctrl_read_end  = 1'b1;
        ctrl_data_read = 32'hBAD0_BAD0;
        cyc();
        chk("t2_issue_busy", 32'(busy), 32'd1);
        chk("t2_issue_end", 32'(p0_end), 32'd0);
        chk("t2_issue_data", p0_data, 32'h1234_5678);
        ctrl_data_read = 32'hCAFE_F00D;
        p0_re = 1'b0;
        cyc();
        ctrl_read_end = 1'b0;
        chk("t2_p0_end", 32'(p0_end), 32'd1);
        chk("t2_p0_data", p0_data, 32'hCAFE_F00D);
        cyc();

        // Contention from reset alternates p0, p1, p0, p1
        reset = 1'b0;
        cyc();
        cyc();
        reset     = 1'b1;
        p0_re     = 1'b1;
        p1_re     = 1'b1;
        p0_addr   = 32'h0000_1000;
        p1_addr   = 32'h0000_2000;
        auto_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_busy(1'b1, "t3_wait_grant");
            chk("t3_grant_order", 32'(grant), 32'(gseq[i]));
            wait_busy(1'b0, "t3_wait_idle");
        end
        p0_re = 1'b0;
        p1_re = 1'b0;

        // p1 timeout with no completion
        auto_resp     = 1'b0;
        ctrl_read_end = 1'b0;
        keep1   = m_data[1];
        p1_re   = 1'b1;
        p1_addr = 32'hA5A5_0040;
        n = 0;
        do begin
            cyc();
            n++;
            if (n == 1) begin
                chk("t4_grant", 32'(grant), 32'd2);
                p1_re = 1'b0;
            end
        end while (!p1_end && n < 40);
        chk("t4_latency", 32'(n), 32'd10);
        chk("t4_p1_err", 32'(p1_err), 32'd1);
        chk("t4_resp_re", 32'(ctrl_re), 32'd0);
        chk("t4_p1_data", p1_data, keep1);
        cyc();

        // Reset during WAIT aborts, then a fresh request is served
        p0_re   = 1'b1;
        p0_addr = 32'h0000_0400;
        cyc();
        p0_re = 1'b0;
        cyc();
        cyc();
        #2 reset = 1'b0;
        #1;
        chk("t5_ctrl_re", 32'(ctrl_re), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_ctrl_addr", ctrl_addr, 32'd0);
        chk("t5_p0_end", 32'(p0_end), 32'd0);
        cyc();
        reset     = 1'b1;
        p1_re     = 1'b1;
        p1_addr   = 32'h0000_0500;
        auto_resp = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!p1_end && n < 100);
        chk("t5_recover_end", 32'(p1_end), 32'd1);
        p1_re = 1'b0;
        cyc();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (p0_re && p0_end) p0_re = 1'b0;
            else if (!p0_re && $urandom_range(0, 2) == 0) begin
                p0_re   = 1'b1;
                p0_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) p0_re = 1'b0;
            else if ($urandom_range(0, 7) == 0) p0_addr = $urandom;
            if (p1_re && p1_end) p1_re = 1'b0;
            else if (!p1_re && $urandom_range(0, 2) == 0) begin
                p1_re   = 1'b1;
                p1_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) p1_re = 1'b0;
            else if ($urandom_range(0, 7) == 0) p1_addr = $urandom;
            if (i % 700 == 350) begin
                #2 reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
